// File: rtl/down_counter_4_bit.sv
// Loadable, prescaled down counter with one-shot / auto-reload modes and a one-cycle terminal-count pulse.
// Optional sticky terminal-count flag (tc_clr / tc_flag) enabled by defining DOWN_COUNTER_STICKY_TC_EN.
module down_counter_4_bit #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             busy
`ifdef DOWN_COUNTER_STICKY_TC_EN
    ,
    input  logic             tc_clr,
    output logic             tc_flag
`endif
);

    localparam int unsigned PW = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_busy;
    logic             w_tick;

    assign w_tick = (r_state == RUN) && en && (r_presc == PW'(PRESCALE - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath; load outranks any coincident tick
    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_reload_nxt = r_reload;
        w_mode_nxt   = r_mode;
        w_presc_nxt  = r_presc;
        w_tc_nxt     = 1'b0;
        if (load) begin
            w_out_nxt    = load_val;
            w_reload_nxt = load_val;
            w_mode_nxt   = mode;
            w_presc_nxt  = '0;
            w_state_nxt  = (load_val != '0) ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_presc_nxt = '0;
                end
                RUN: begin
                    if (w_tick) begin
                        w_presc_nxt = '0;
                        if (r_out == WIDTH'(1)) begin
                            w_tc_nxt = 1'b1;
                            if (r_mode) begin
                                w_out_nxt = r_reload;
                            end else begin
                                w_out_nxt   = '0;
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_out_nxt = r_out - WIDTH'(1);
                        end
                    end else if (en) begin
                        w_presc_nxt = r_presc + PW'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_presc  <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_out    <= w_out_nxt;
            r_reload <= w_reload_nxt;
            r_mode   <= w_mode_nxt;
            r_presc  <= w_presc_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= (w_state_nxt == RUN);
        end
    end

    assign out  = r_out;
    assign tc   = r_tc;
    assign busy = r_busy;

`ifdef DOWN_COUNTER_STICKY_TC_EN
    logic r_tc_flag;

    // Sticky flag rises together with tc; a set beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc_flag <= 1'b0;
        end else if (w_tc_nxt) begin
            r_tc_flag <= 1'b1;
        end else if (tc_clr) begin
            r_tc_flag <= 1'b0;
        end
    end

    assign tc_flag = r_tc_flag;
`endif

endmodule

// File: tb/tb_down_counter_4_bit.sv
// Scoreboard bench for down_counter_4_bit: PRESCALE=1 and PRESCALE=4 instances, directed vectors.
module tb_down_counter_4_bit;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1, load1 = 1'b0, mode1 = 1'b0, en1 = 1'b0;
    logic [3:0] val1 = 4'd0;
    logic [3:0] out1;
    logic       tc1, busy1;
    logic       rst4 = 1'b1, load4 = 1'b0, mode4 = 1'b0, en4 = 1'b0;
    logic [3:0] val4 = 4'd0;
    logic [3:0] out4;
    logic       tc4, busy4;
`ifdef DOWN_COUNTER_STICKY_TC_EN
    logic       tc_clr1 = 1'b0, tc_clr4 = 1'b0;
    logic       tc_flag1, tc_flag4;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit end_chk = 1'b0;

    typedef struct {
        int         cyc;
        bit         sel;
        logic [3:0] out;
        logic       tc;
        logic       busy;
        bit         fchk;
        logic       flag;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    logic [3:0] act_out;
    logic       act_tc, act_busy;

    down_counter_4_bit #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst1), .load(load1), .load_val(val1), .mode(mode1), .en(en1),
        .out(out1), .tc(tc1), .busy(busy1)
`ifdef DOWN_COUNTER_STICKY_TC_EN
        , .tc_clr(tc_clr1), .tc_flag(tc_flag1)
`endif
    );

    down_counter_4_bit #(.WIDTH(4), .PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst4), .load(load4), .load_val(val4), .mode(mode4), .en(en4),
        .out(out4), .tc(tc4), .busy(busy4)
`ifdef DOWN_COUNTER_STICKY_TC_EN
        , .tc_clr(tc_clr4), .tc_flag(tc_flag4)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Apply one cycle of inputs and queue the outputs expected after the next edge
    task automatic vec(input bit sel, input logic r, input logic ld, input logic [3:0] v,
                       input logic m, input logic e, input logic [3:0] eo, input logic et,
                       input logic eb, input string nm, input bit fchk = 1'b0,
                       input logic ef = 1'b0);
        exp_t x;
        if (!sel) begin
            rst1 = r; load1 = ld; val1 = v; mode1 = m; en1 = e;
        end else begin
            rst4 = r; load4 = ld; val4 = v; mode4 = m; en4 = e;
        end
        x.cyc = cyc + 1; x.sel = sel; x.out = eo; x.tc = et; x.busy = eb;
        x.fchk = fchk; x.flag = ef; x.name = nm;
        q.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mon_x    = q.pop_front();
            act_out  = mon_x.sel ? out4  : out1;
            act_tc   = mon_x.sel ? tc4   : tc1;
            act_busy = mon_x.sel ? busy4 : busy1;
            checks++;
            if (mon_x.cyc != cyc || act_out !== mon_x.out || act_tc !== mon_x.tc ||
                act_busy !== mon_x.busy) begin
                errors++;
                $display("FAIL %s cyc=%0d got out=%0d tc=%b busy=%b want out=%0d tc=%b busy=%b",
                         mon_x.name, cyc, act_out, act_tc, act_busy, mon_x.out, mon_x.tc, mon_x.busy);
            end
`ifdef DOWN_COUNTER_STICKY_TC_EN
            if (mon_x.fchk) begin
                checks++;
                if ((mon_x.sel ? tc_flag4 : tc_flag1) !== mon_x.flag) begin
                    errors++;
                    $display("FAIL %s_flag cyc=%0d got tc_flag=%b want %b", mon_x.name, cyc,
                             mon_x.sel ? tc_flag4 : tc_flag1, mon_x.flag);
                end
            end
`endif
        end
        if (end_chk) begin
            end_chk = 1'b0;
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain got %0d pending entries want 0", q.size());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            vec(0, 1, 0, 0, 0, 1, 0, 0, 0, "reset1");
            vec(1, 1, 0, 0, 0, 1, 0, 0, 0, "reset4");
        end

        // One-shot from 5
        vec(0, 0, 1, 5, 0, 1, 5, 0, 1, "os_load");
        for (int i = 4; i >= 1; i--) vec(0, 0, 0, 0, 0, 1, 4'(i), 0, 1, "os_dec");
        vec(0, 0, 0, 0, 0, 1, 0, 1, 0, "os_tc");
        vec(0, 0, 0, 0, 0, 1, 0, 0, 0, "os_hold");
        vec(0, 0, 0, 0, 0, 1, 0, 0, 0, "os_hold");

        // Auto-reload of 3
        vec(0, 0, 1, 3, 1, 1, 3, 0, 1, "ar_load");
        for (int k = 0; k < 3; k++) begin
            vec(0, 0, 0, 0, 0, 1, 2, 0, 1, "ar_2");
            vec(0, 0, 0, 0, 0, 1, 1, 0, 1, "ar_1");
            vec(0, 0, 0, 0, 0, 1, 3, 1, 1, "ar_reload");
        end

        // Maximum load, one-shot, with one stalled cycle
        vec(0, 0, 1, 15, 0, 1, 15, 0, 1, "max_load");
        vec(0, 0, 0, 0, 0, 0, 15, 0, 1, "max_stall");
        for (int i = 14; i >= 1; i--) vec(0, 0, 0, 0, 0, 1, 4'(i), 0, 1, "max_dec");
        vec(0, 0, 0, 0, 0, 1, 0, 1, 0, "max_tc");
        vec(0, 0, 0, 0, 0, 1, 0, 0, 0, "idle_hold");

        // Load beats the 1->0 tick, then zero load
        vec(0, 0, 1, 2, 0, 1, 2, 0, 1, "pri_load");
        vec(0, 0, 0, 0, 0, 1, 1, 0, 1, "pri_1");
        vec(0, 0, 1, 9, 0, 1, 9, 0, 1, "pri_reload9");
        vec(0, 0, 0, 0, 0, 1, 8, 0, 1, "pri_8");
        vec(0, 0, 1, 0, 0, 1, 0, 0, 0, "zero_load");
        vec(0, 0, 0, 0, 0, 1, 0, 0, 0, "zero_idle");
        vec(0, 0, 0, 0, 0, 1, 0, 0, 0, "zero_idle");

        // Mid-run reset in auto-reload
        vec(0, 0, 1, 8, 1, 1, 8, 0, 1, "mr_load");
        vec(0, 0, 0, 0, 0, 1, 7, 0, 1, "mr_7");
        vec(0, 0, 0, 0, 0, 1, 6, 0, 1, "mr_6");
        vec(0, 1, 0, 0, 0, 1, 0, 0, 0, "mr_reset");
        vec(0, 0, 0, 0, 0, 1, 0, 0, 0, "mr_idle");
        vec(0, 0, 0, 0, 0, 1, 0, 0, 0, "mr_idle");

        // PRESCALE=4 with a 7-cycle enable stall
        vec(1, 0, 0, 0, 0, 1, 0, 0, 0, "p4_idle");
        vec(1, 0, 1, 2, 0, 1, 2, 0, 1, "p4_load");
        for (int i = 0; i < 3; i++) vec(1, 0, 0, 0, 0, 1, 2, 0, 1, "p4_pre2");
        vec(1, 0, 0, 0, 0, 1, 1, 0, 1, "p4_dec1");
        for (int i = 0; i < 2; i++) vec(1, 0, 0, 0, 0, 1, 1, 0, 1, "p4_pre1");
        for (int i = 0; i < 7; i++) vec(1, 0, 0, 0, 0, 0, 1, 0, 1, "p4_stall");
        vec(1, 0, 0, 0, 0, 1, 1, 0, 1, "p4_pre1b");
        vec(1, 0, 0, 0, 0, 1, 0, 1, 0, "p4_tc");
        vec(1, 0, 0, 0, 0, 1, 0, 0, 0, "p4_hold");

`ifdef DOWN_COUNTER_STICKY_TC_EN
        // Sticky flag: set beats simultaneous clear; a lone clear drops it
        vec(0, 1, 0, 0, 0, 1, 0, 0, 0, "st_reset", 1, 0);
        vec(0, 0, 1, 2, 1, 1, 2, 0, 1, "st_load", 1, 0);
        vec(0, 0, 0, 0, 0, 1, 1, 0, 1, "st_1", 1, 0);
        vec(0, 0, 0, 0, 0, 1, 2, 1, 1, "st_tc1", 1, 1);
        tc_clr1 = 1'b1;
        vec(0, 0, 0, 0, 0, 1, 1, 0, 1, "st_clr_no_tc_prev", 1, 0);
        tc_clr1 = 1'b0;
        vec(0, 0, 0, 0, 0, 1, 2, 1, 1, "st_tc2", 1, 1);
        tc_clr1 = 1'b1;
        vec(0, 0, 0, 0, 0, 1, 1, 0, 1, "st_lone_clr", 1, 0);
        tc_clr1 = 1'b0;
        vec(0, 0, 0, 0, 0, 1, 2, 1, 1, "st_tc3", 1, 1);
        tc_clr1 = 1'b1;
        vec(0, 0, 0, 0, 0, 1, 1, 0, 1, "st_clr_before", 1, 0);
        // clear and tc coincide on this edge: set wins
        vec(0, 0, 0, 0, 0, 1, 2, 1, 1, "st_clr_with_tc", 1, 1);
        tc_clr1 = 1'b0;
        vec(0, 0, 1, 5, 0, 1, 5, 0, 1, "st_load_keeps", 1, 1);
        tc_clr1 = 1'b1;
        vec(0, 0, 0, 0, 0, 1, 4, 0, 1, "st_final_clr", 1, 0);
        tc_clr1 = 1'b0;
`endif

        end_chk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/down_counter_4_bit.md
Name: down_counter_4_bit

Overview:
- Loadable, prescaled down counter; the count-down companion to the free-running 4-bit up counter used across the design.
- Loads a start value, decrements once per prescaler tick while enabled, and flags terminal count.
- Runs in one-shot mode or auto-reload mode, so it can act as a periodic timer or a single delay for downstream control logic.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESCALE, 1, clock cycles per decrement tick. Legal range is 1..255. The internal prescaler is 8 bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- load  input  1  one-cycle strobe; captures load_val and mode.
- load_val  input  WIDTH  start/reload value.
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled only on load.
- en  input  1  count enable; low freezes both prescaler and count.
- out  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse, exactly one clk wide (registered).
- busy  output  1  high while in RUN state.

Behaviour:
- Reset (rst=1 at an edge):
  - out=0, tc=0, busy=0, state=IDLE.
  - Prescaler=0, reload_reg=0, mode_reg=0.
  - rst overrides all other inputs.
- States: IDLE and RUN. busy = (state==RUN).
- Tick definition: tick = state==RUN && en && prescaler==PRESCALE-1.
- Prescaler:
  - Increments each cycle that RUN && en holds; wraps to 0 on tick.
  - Holds while en=0.
  - Cleared on load and in IDLE.
  - With PRESCALE=1, every enabled RUN cycle is a tick.
- Load (priority below rst, above everything else, in any state):
  - Next cycle: out=load_val, reload_reg=load_val, mode_reg=mode, prescaler=0, tc=0.
  - load_val != 0: state becomes RUN.
  - load_val == 0: state becomes IDLE, no tc is generated.
  - A load during RUN restarts the count and suppresses any coincident tick and its tc.
- Tick in RUN with out > 1: out <= out-1, tc=0.
- Tick in RUN with out == 1:
  - tc=1 for the next cycle only.
  - mode_reg=0: out <= 0, state <= IDLE.
  - mode_reg=1: out <= reload_reg and state stays RUN. The period is therefore exactly reload_reg ticks, and out never shows 0 in this mode.
- IDLE: out holds, tc=0, en is ignored.
- Latency:
  - load to first out change: 1 cycle.
  - tick to out/tc update: 1 cycle, registered.
  - tc is high in the same cycle out first shows 0 (one-shot) or the reload value (auto-reload).
- Width/arithmetic:
  - Decrement is modulo 2^WIDTH but never underflows, because out==1 is handled explicitly.
  - load_val = 2^WIDTH-1 is legal and gives the maximum delay.
- en toggled mid-count: no tick is lost or duplicated; the prescaler phase is preserved.

Optional Feature:
- Macro: DOWN_COUNTER_STICKY_TC_EN.
- When defined, adds two ports:
  - input tc_clr (1 bit).
  - output tc_flag (1 bit).
- tc_flag rules:
  - Set the cycle tc is asserted; stays high until tc_clr=1 at an edge.
  - Set wins over a simultaneous tc_clr.
  - Cleared by rst. load does not clear it.
- When undefined, neither port nor the flag register exists, and all other behaviour is identical.

Test Plan:
- Reset and one-shot count (PRESCALE=1):
  - Stimulus: rst high 10 cycles, then load=1, load_val=5, mode=0, en=1.
  - Response: out goes 5,4,3,2,1,0 on consecutive cycles; tc=1 only in the cycle out=0; busy falls with it; out then holds 0.
- Auto-reload (PRESCALE=1):
  - Stimulus: load_val=3, mode=1, en=1.
  - Response: out cycles 3,2,1,3,2,1...; tc pulses every 3 cycles, each coinciding with out=3 after the first reload; busy stays 1.
- Prescale and enable (PRESCALE=4):
  - Stimulus: load_val=2, mode=0; hold en low for 7 cycles mid-count.
  - Response: each decrement takes 4 enabled cycles; total time from load to tc is 8 enabled cycles plus 7 stalled cycles.
- Load priority and zero load:
  - Stimulus: reload with 9 in the same cycle out would go 1 to 0.
  - Response: out=9, no tc.
  - Stimulus: then load_val=0.
  - Response: out=0, busy=0, tc never pulses.
- Mid-run reset:
  - Stimulus: rst=1 for one cycle at out=6, mode=1.
  - Response: next cycle out=0, busy=0, tc=0; the counter stays IDLE with en=1 until the next load.
- DOWN_COUNTER_STICKY_TC_EN:
  - Stimulus: let tc fire, then assert tc_clr in the same cycle as a second tc.
  - Response: tc_flag rises with the first tc, remains 1 through the simultaneous clear, and drops only after a later lone tc_clr.
